// File: rtl/data_reg_file.sv
// Register bank on the control unit's data-memory port: single-cycle writes,
// registered reads with a valid strobe, and a one-entry-per-cycle clear sequencer.
module data_reg_file #(
  parameter int DW = 9,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  input  logic          wr,
  input  logic          rd,
  input  logic          clr,
  output logic [DW-1:0] data_out,
  output logic          rd_valid,
  output logic          busy,
  output logic          req_drop
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [AW-1:0]             idx_reg, idx_next;
  logic [DEPTH-1:0][DW-1:0]  mem_reg, mem_next;
  logic [DW-1:0]             data_out_reg, data_out_next;
  logic                      rd_valid_reg, rd_valid_next;
  logic                      req_drop_reg, req_drop_next;
  logic                      accept;

  // Requests are served only while idle and not in the cycle that starts a clear.
  assign accept = (state_reg == IDLE) && !clr;

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    data_out_next = data_out_reg;
    rd_valid_next = 1'b0;
    req_drop_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr) begin
          state_next    = CLEAR;
          req_drop_next = rd | wr;
        end else if (rd) begin
          // Write-first: a concurrent write to the same entry is returned directly.
          data_out_next = wr ? data_in : mem_reg[addr];
          rd_valid_next = 1'b1;
        end
      end
      CLEAR: begin
        req_drop_next = rd | wr;
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic clear_hit;
      logic write_hit;
      assign clear_hit   = (state_reg == CLEAR) && (idx_reg == AW'(gi));
      assign write_hit   = accept && wr && (addr == AW'(gi));
      assign mem_next[gi] = clear_hit ? '0 :
                            write_hit ? data_in : mem_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      mem_reg      <= '0;
      data_out_reg <= '0;
      rd_valid_reg <= 1'b0;
      req_drop_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      mem_reg      <= mem_next;
      data_out_reg <= data_out_next;
      rd_valid_reg <= rd_valid_next;
      req_drop_reg <= req_drop_next;
    end
  end

  assign data_out = data_out_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg == CLEAR);
  assign req_drop = req_drop_reg;

endmodule

// File: tb/tb_data_reg_file.sv
// Randomized and directed bench for data_reg_file, checked against an
// array-based reference of the bank, read port and clear sequence.
module tb_data_reg_file;

  localparam int DW    = 9;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          busy;
  logic          req_drop;

  data_reg_file #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .clr      (clr),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .busy     (busy),
    .req_drop (req_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_dout;
  bit            ref_rdv;
  bit            ref_drop;
  int            clear_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_dout   = '0;
    ref_rdv    = 1'b0;
    ref_drop   = 1'b0;
    clear_left = 0;
  endtask

  // One clock edge of the reference: a clear takes DEPTH edges after it is
  // accepted, zeroing entries in ascending order; anything requested meanwhile is lost.
  task automatic ref_edge(input bit r, input bit w, input bit c,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_rdv  = 1'b0;
    ref_drop = 1'b0;
    if (clear_left > 0) begin
      ref_mem[DEPTH - clear_left] = '0;
      clear_left--;
      ref_drop = r | w;
    end else if (c) begin
      clear_left = DEPTH;
      ref_drop   = r | w;
    end else begin
      if (w) ref_mem[a] = d;
      if (r) begin
        ref_dout = ref_mem[a];
        ref_rdv  = 1'b1;
      end
    end
  endtask

  task automatic step(input bit r, input bit w, input bit c,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd = r; wr = w; clr = c; addr = a; data_in = d;
    @(posedge clk);
    ref_edge(r, w, c, a, d);
    #1;
    check("data_out", {23'd0, data_out}, {23'd0, ref_dout});
    check("rd_valid", {31'd0, rd_valid}, {31'd0, ref_rdv});
    check("busy",     {31'd0, busy},     {31'd0, clear_left > 0});
    check("req_drop", {31'd0, req_drop}, {31'd0, ref_drop});
    $display("txn t=%0t rd=%0b wr=%0b clr=%0b addr=%0d din=%03h -> dout=%03h vld=%0b busy=%0b drop=%0b",
             $time, r, w, c, a, d, data_out, rd_valid, busy, req_drop);
    rd = 1'b0; wr = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  int busy_cycles;

  initial begin
    ref_reset();

    // 1: asynchronous reset asserted mid-cycle, outputs clear without an edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_data_out", {23'd0, data_out}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_req_drop", {31'd0, req_drop}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, AW'(i), '0);
      check("rst_read_zero", {23'd0, data_out}, 32'd0);
    end

    // 2: write then read with one-cycle latency, data held afterwards
    step(1'b0, 1'b1, 1'b0, 3'd3, 9'h1A5);
    step(1'b1, 1'b0, 1'b0, 3'd3, '0);
    check("t2_dout",  {23'd0, data_out}, 32'h1A5);
    check("t2_valid", {31'd0, rd_valid}, 32'd1);
    idle(1);
    check("t2_valid_low", {31'd0, rd_valid}, 32'd0);
    check("t2_dout_hold", {23'd0, data_out}, 32'h1A5);

    // 3: simultaneous read and write is write-first
    step(1'b0, 1'b1, 1'b0, 3'd5, 9'h011);
    step(1'b1, 1'b1, 1'b0, 3'd5, 9'h0FF);
    check("t3_wf_dout", {23'd0, data_out}, 32'h0FF);
    step(1'b1, 1'b0, 1'b0, 3'd5, '0);
    check("t3_reread", {23'd0, data_out}, 32'h0FF);

    // 4: fill, clear, busy for exactly DEPTH cycles, bank reads zero
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, AW'(i), DW'(37 * i + 3));
    busy_cycles = 0;
    step(1'b0, 1'b0, 1'b1, '0, '0);
    if (busy) busy_cycles++;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (busy) busy_cycles++;
    end
    check("t4_busy_cycles", busy_cycles, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, AW'(i), '0);
      check("t4_cleared", {23'd0, data_out}, 32'd0);
    end

    // 5: requests during clear are dropped; a repeated clr is ignored
    step(1'b0, 1'b1, 1'b0, 3'd2, 9'h0AA);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b1, 1'b0, 3'd2, 9'h155);
    check("t5_wr_drop", {31'd0, req_drop}, 32'd1);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check("t5_drop_pulse", {31'd0, req_drop}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 3'd2, '0);
    check("t5_rd_drop",  {31'd0, req_drop}, 32'd1);
    check("t5_rd_valid", {31'd0, rd_valid}, 32'd0);
    idle(6);
    check("t5_done", {31'd0, busy}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 3'd2, '0);
    check("t5_addr2_zero", {23'd0, data_out}, 32'd0);

    // 6: reset while the clear index is 4
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, AW'(i), DW'(i + 100));
    step(1'b0, 1'b0, 1'b1, '0, '0);
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy_abort", {31'd0, busy}, 32'd0);
    check("t6_dout_rst",   {23'd0, data_out}, 32'd0);
    ref_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, AW'(i), '0);
      check("t6_read_zero", {23'd0, data_out}, 32'd0);
    end
    busy_cycles = 0;
    step(1'b0, 1'b0, 1'b1, '0, '0);
    if (busy) busy_cycles++;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (busy) busy_cycles++;
    end
    check("t6_full_clear", busy_cycles, DEPTH);

    // Randomized traffic against the reference
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 24) == 0), AW'($urandom), DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
